// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data memory request/ack bus between mem_stage and data memory
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with MEM/WB register, optional alignment check (MEM_ALIGN_CHK_EN)
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic [15:0]        alu_out,
    input  logic [15:0]        wr_data,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [2:0]         writereg_in,
    input  logic               regwrite_in,
    input  logic               halt_in,
    input  logic               flush,
    mem_stage_if.master        dmem,
    output logic               stall,
    output logic               wb_valid,
    output logic               wb_regwrite,
    output logic               wb_halt,
    output logic [2:0]         wb_writereg,
    output logic [15:0]        wb_mem_out,
    output logic [15:0]        wb_alu_out,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_nxt;

    // Transaction latches: everything needed to finish the instruction once
    // upstream has moved on.
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic        regwrite_q;
    logic        halt_q;
    logic [2:0]  writereg_q;

    logic        accept;
    logic        any_mem;
    logic        bad_op;
    logic        mem_op;
    logic        ack;
    logic        timeout_hit;
    logic        txn_done;

    assign accept  = ex_valid & ~flush;
    assign any_mem = mem_read | mem_write;

`ifdef MEM_ALIGN_CHK_EN
    // Odd addresses are rejected like a conflicting read/write request.
    assign bad_op  = (mem_read & mem_write) | (any_mem & alu_out[0]);
`else
    assign bad_op  = mem_read & mem_write;
`endif

    assign mem_op      = any_mem & ~bad_op;
    assign ack         = dmem.dmem_ack;
    assign wait_nxt    = wait_cnt + 8'd1;
    // An ack always wins over a timeout reached in the same cycle.
    assign timeout_hit = ~ack & (wait_nxt == TIMEOUT_CNT);
    assign txn_done    = ack | timeout_hit;

    // Bus outputs come straight from the latches so they stay stable until ack.
    assign dmem.dmem_req   = (state == REQ);
    assign dmem.dmem_we    = (state == REQ) & we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and stall decode.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (mem_op) begin
                        state_nxt = REQ;
                        stall     = 1'b1;
                    end else if (halt_in) begin
                        state_nxt = HALTED;
                    end
                end
            end
            REQ: begin
                stall = ~ack;
                if (txn_done) begin
                    state_nxt = halt_q ? HALTED : IDLE;
                end
            end
            HALTED: begin
                stall = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Wait counter: held at zero outside REQ so every transaction starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (state != REQ) begin
            wait_cnt <= 8'd0;
        end else if (!ack) begin
            wait_cnt <= wait_nxt;
        end
    end

    // Capture the memory instruction at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= 16'd0;
            wdata_q    <= 16'd0;
            we_q       <= 1'b0;
            regwrite_q <= 1'b0;
            halt_q     <= 1'b0;
            writereg_q <= 3'd0;
        end else if ((state == IDLE) && accept && mem_op) begin
            addr_q     <= alu_out;
            wdata_q    <= wr_data;
            we_q       <= mem_write;
            regwrite_q <= regwrite_in;
            halt_q     <= halt_in;
            writereg_q <= writereg_in;
        end
    end

    // MEM/WB register and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_halt     <= 1'b0;
            wb_writereg <= 3'd0;
            wb_mem_out  <= 16'd0;
            wb_alu_out  <= 16'd0;
            err         <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bad_op) begin
                            err <= 1'b1;
                        end
                        if (!mem_op) begin
                            wb_valid    <= 1'b1;
                            wb_regwrite <= regwrite_in & ~bad_op;
                            wb_halt     <= halt_in;
                            wb_writereg <= writereg_in;
                            wb_mem_out  <= 16'd0;
                            wb_alu_out  <= alu_out;
                        end
                    end
                end
                REQ: begin
                    if (txn_done) begin
                        wb_valid    <= 1'b1;
                        wb_regwrite <= regwrite_q & ack;
                        wb_halt     <= halt_q;
                        wb_writereg <= writereg_q;
                        wb_mem_out  <= (ack && !we_q) ? dmem.dmem_rdata : 16'd0;
                        wb_alu_out  <= addr_q;
                        if (timeout_hit) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    wb_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a transaction-level reference model
module tb_mem_stage;

    localparam int TO = 4;
`ifdef MEM_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid;
    logic [15:0] alu_out;
    logic [15:0] wr_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  writereg_in;
    logic        regwrite_in;
    logic        halt_in;
    logic        flush;
    logic        stall;
    logic        wb_valid;
    logic        wb_regwrite;
    logic        wb_halt;
    logic [2:0]  wb_writereg;
    logic [15:0] wb_mem_out;
    logic [15:0] wb_alu_out;
    logic        err;

    mem_stage_if dmem ();

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .alu_out     (alu_out),
        .wr_data     (wr_data),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .writereg_in (writereg_in),
        .regwrite_in (regwrite_in),
        .halt_in     (halt_in),
        .flush       (flush),
        .dmem        (dmem),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_regwrite (wb_regwrite),
        .wb_halt     (wb_halt),
        .wb_writereg (wb_writereg),
        .wb_mem_out  (wb_mem_out),
        .wb_alu_out  (wb_alu_out),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int stall_cycles = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: one pending transaction plus the expected MEM/WB contents.
    bit          m_busy;
    bit          m_halted;
    int          m_waits;
    logic [15:0] p_addr;
    logic [15:0] p_wdata;
    logic        p_we;
    logic        p_rw;
    logic        p_halt;
    logic [2:0]  p_reg;
    logic        e_valid;
    logic        e_rw;
    logic        e_halt;
    logic [2:0]  e_reg;
    logic [15:0] e_mem;
    logic [15:0] e_alu;
    logic        e_err;

    function automatic void model_reset();
        m_busy = 0; m_halted = 0; m_waits = 0;
        p_addr = '0; p_wdata = '0; p_we = 0; p_rw = 0; p_halt = 0; p_reg = '0;
        e_valid = 0; e_rw = 0; e_halt = 0; e_reg = '0; e_mem = '0; e_alu = '0; e_err = 0;
    endfunction

    function automatic void finish_txn(input bit ok, input logic [15:0] data);
        e_valid = 1; e_rw = p_rw & ok; e_halt = p_halt; e_reg = p_reg;
        e_mem = data; e_alu = p_addr; m_busy = 0;
        if (p_halt) m_halted = 1;
    endfunction

    // Compare DUT against the model every cycle, then advance the model with
    // the inputs the DUT is about to sample.
    always @(negedge clk) begin
        bit is_mem;
        bit bad;
        bit xs;
        bit xr;
        if (!rst_n) model_reset();
        is_mem = mem_read | mem_write;
        bad = (mem_read & mem_write) | (ALIGN_CHK & is_mem & alu_out[0]);
        xr = m_busy && !m_halted;
        xs = m_halted || (m_busy && !dmem.dmem_ack) ||
             (!m_busy && ex_valid && !flush && is_mem && !bad);
        check("wb_valid", 16'(wb_valid), 16'(e_valid));
        check("wb_regwrite", 16'(wb_regwrite), 16'(e_rw));
        check("wb_halt", 16'(wb_halt), 16'(e_halt));
        check("wb_writereg", 16'(wb_writereg), 16'(e_reg));
        check("wb_mem_out", wb_mem_out, e_mem);
        check("wb_alu_out", wb_alu_out, e_alu);
        check("err", 16'(err), 16'(e_err));
        check("stall", 16'(stall), 16'(xs));
        check("dmem_req", 16'(dmem.dmem_req), 16'(xr));
        if (xr) begin
            check("dmem_addr", dmem.dmem_addr, p_addr);
            check("dmem_wdata", dmem.dmem_wdata, p_wdata);
            check("dmem_we", 16'(dmem.dmem_we), 16'(p_we));
        end
        if (stall) stall_cycles++;
        if (rst_n) begin
            if (m_halted) begin
                e_valid = 0;
            end else if (m_busy) begin
                if (dmem.dmem_ack) begin
                    finish_txn(1, p_we ? 16'h0000 : dmem.dmem_rdata);
                end else begin
                    m_waits++;
                    if (m_waits == TO) begin
                        e_err = 1;
                        finish_txn(0, 16'h0000);
                    end else begin
                        e_valid = 0;
                    end
                end
            end else begin
                e_valid = 0;
                if (ex_valid && !flush) begin
                    if (is_mem && !bad) begin
                        m_busy = 1; m_waits = 0;
                        p_addr = alu_out; p_wdata = wr_data; p_we = mem_write;
                        p_rw = regwrite_in; p_halt = halt_in; p_reg = writereg_in;
                    end else begin
                        e_valid = 1; e_rw = regwrite_in & ~bad; e_halt = halt_in;
                        e_reg = writereg_in; e_mem = 16'h0000; e_alu = alu_out;
                        if (bad) e_err = 1;
                        if (halt_in) m_halted = 1;
                    end
                end
            end
        end
    end

    task automatic present(input logic v, input logic [15:0] a, input logic [15:0] d,
                           input logic rd, input logic wr, input logic [2:0] r,
                           input logic rw, input logic h, input logic fl);
        ex_valid = v; alu_out = a; wr_data = d; mem_read = rd; mem_write = wr;
        writereg_in = r; regwrite_in = rw; halt_in = h; flush = fl;
    endtask

    task automatic idle_in();
        present(0, 16'h0000, 16'h0000, 0, 0, 3'd0, 0, 0, 0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        step(1);
        rst_n = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        idle_in();
        dmem.dmem_ack = 0;
        dmem.dmem_rdata = 16'h0000;
        rst_n = 0;
        step(2);
        check("reset_wb_valid", 16'(wb_valid), 16'h0);
        check("reset_err", 16'(err), 16'h0);
        check("reset_dmem_req", 16'(dmem.dmem_req), 16'h0);
        rst_n = 1;
        step(1);

        // ALU op: one-cycle latency, no stall
        stall_cycles = 0;
        present(1, 16'h1234, 16'h0000, 0, 0, 3'd5, 1, 0, 0);
        step(1);
        idle_in();
        check("add_wb_alu_out", wb_alu_out, 16'h1234);
        check("add_wb_writereg", 16'(wb_writereg), 16'h5);
        check("add_wb_valid", 16'(wb_valid), 16'h1);
        check("add_stall_cycles", 16'(stall_cycles), 16'h0);
        step(1);

        // Load with ack after 3 wait cycles (ack coincides with the timeout count)
        stall_cycles = 0;
        present(1, 16'h0010, 16'h0000, 1, 0, 3'd3, 1, 0, 0);
        step(1);
        check("load_dmem_req", 16'(dmem.dmem_req), 16'h1);
        check("load_dmem_addr", dmem.dmem_addr, 16'h0010);
        step(3);
        dmem.dmem_ack = 1; dmem.dmem_rdata = 16'hBEEF;
        step(1);
        dmem.dmem_ack = 0;
        idle_in();
        check("load_wb_mem_out", wb_mem_out, 16'hBEEF);
        check("load_wb_valid", 16'(wb_valid), 16'h1);
        check("load_stall_cycles", 16'(stall_cycles), 16'h4);
        check("load_no_err", 16'(err), 16'h0);
        step(2);

        // Store that never gets an ack: times out after 4 wait cycles
        stall_cycles = 0;
        present(1, 16'h0020, 16'h00FF, 0, 1, 3'd6, 1, 0, 0);
        step(1);
        check("store_dmem_we", 16'(dmem.dmem_we), 16'h1);
        check("store_dmem_wdata", dmem.dmem_wdata, 16'h00FF);
        step(3);
        check("store_err_before_timeout", 16'(err), 16'h0);
        step(1);
        idle_in();
        check("timeout_err", 16'(err), 16'h1);
        check("timeout_wb_regwrite", 16'(wb_regwrite), 16'h0);
        check("timeout_wb_valid", 16'(wb_valid), 16'h1);
        check("timeout_back_idle", 16'(dmem.dmem_req), 16'h0);
        check("timeout_stall_cycles", 16'(stall_cycles), 16'h5);
        step(2);

        // Flush in IDLE drops the load; flush during REQ is ignored
        do_reset();
        present(1, 16'h0030, 16'h0000, 1, 0, 3'd1, 1, 0, 1);
        step(1);
        check("flush_idle_wb_valid", 16'(wb_valid), 16'h0);
        check("flush_idle_no_req", 16'(dmem.dmem_req), 16'h0);
        present(1, 16'h0040, 16'h0000, 1, 0, 3'd2, 1, 0, 0);
        step(1);
        present(1, 16'h0040, 16'h0000, 1, 0, 3'd2, 1, 0, 1);
        step(1);
        check("flush_req_held", 16'(dmem.dmem_req), 16'h1);
        dmem.dmem_ack = 1; dmem.dmem_rdata = 16'h1357;
        step(1);
        dmem.dmem_ack = 0;
        idle_in();
        check("flush_req_wb_valid", 16'(wb_valid), 16'h1);
        check("flush_req_wb_mem_out", wb_mem_out, 16'h1357);
        step(1);

        // Conflicting read+write: error, no request, regwrite suppressed
        do_reset();
        present(1, 16'h0050, 16'h0000, 1, 1, 3'd2, 1, 0, 0);
        step(1);
        idle_in();
        check("illegal_err", 16'(err), 16'h1);
        check("illegal_wb_valid", 16'(wb_valid), 16'h1);
        check("illegal_wb_regwrite", 16'(wb_regwrite), 16'h0);
        check("illegal_no_req", 16'(dmem.dmem_req), 16'h0);
        step(1);

        // Odd address load
        do_reset();
        present(1, 16'h0011, 16'h0000, 1, 0, 3'd1, 1, 0, 0);
        step(1);
`ifdef MEM_ALIGN_CHK_EN
        idle_in();
        check("misalign_err", 16'(err), 16'h1);
        check("misalign_no_req", 16'(dmem.dmem_req), 16'h0);
        check("misalign_wb_regwrite", 16'(wb_regwrite), 16'h0);
`else
        check("odd_req", 16'(dmem.dmem_req), 16'h1);
        check("odd_addr", dmem.dmem_addr, 16'h0011);
        dmem.dmem_ack = 1; dmem.dmem_rdata = 16'h2468;
        step(1);
        dmem.dmem_ack = 0;
        idle_in();
        check("odd_wb_mem_out", wb_mem_out, 16'h2468);
        check("odd_no_err", 16'(err), 16'h0);
`endif
        step(1);

        // Reset mid-transaction, then a late ack
        do_reset();
        present(1, 16'h0060, 16'h0000, 1, 0, 3'd4, 1, 0, 0);
        step(1);
        check("midreq_req_up", 16'(dmem.dmem_req), 16'h1);
        idle_in();
        #2;
        rst_n = 0;
        #1;
        check("midreq_req_drop", 16'(dmem.dmem_req), 16'h0);
        check("midreq_wb_valid", 16'(wb_valid), 16'h0);
        step(1);
        rst_n = 1;
        dmem.dmem_ack = 1; dmem.dmem_rdata = 16'hDEAD;
        step(1);
        dmem.dmem_ack = 0;
        check("late_ack_wb_valid", 16'(wb_valid), 16'h0);
        check("late_ack_wb_mem_out", wb_mem_out, 16'h0000);

        // Halt: wb_halt pulses with the instruction, then the stage stays stalled
        present(1, 16'h0070, 16'h0000, 0, 0, 3'd0, 0, 1, 0);
        step(1);
        check("halt_wb_halt", 16'(wb_halt), 16'h1);
        check("halt_wb_valid", 16'(wb_valid), 16'h1);
        present(1, 16'h0099, 16'h0000, 0, 0, 3'd4, 1, 0, 0);
        step(3);
        check("halted_stall", 16'(stall), 16'h1);
        check("halted_wb_valid", 16'(wb_valid), 16'h0);
        check("halted_wb_alu_out", wb_alu_out, 16'h0070);
        idle_in();
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
